time_parameter_timer: RTL

//  Parametrised time-parameter store with an integrated countdown timer for the car

---
 rtl/time_parameter_pkg.sv | 25 ++
 rtl/time_parameter_bank.sv | 48 ++++
 rtl/time_parameter_timer.sv | 100 ++++++++++
 3 files changed

// File: rtl/time_parameter_pkg.sv
// Shared types and constants for the car-security time-parameter store and its
// countdown timer.
package time_parameter_pkg;

  typedef enum logic [1:0] {
    TIMER_IDLE,
    TIMER_COUNT,
    TIMER_EXPIRE
  } timer_state_t;

  localparam int T_ARM_DELAY       = 0;
  localparam int T_DRIVER_DELAY    = 1;
  localparam int T_PASSENGER_DELAY = 2;
  localparam int T_ALARM_ON        = 3;

  localparam logic [3:0] ARM_DEFAULT       = 4'd6;
  localparam logic [3:0] DRIVER_DEFAULT    = 4'd8;
  localparam logic [3:0] PASSENGER_DEFAULT = 4'd15;
  localparam logic [3:0] ALARM_ON_DEFAULT  = 4'd10;

  // Index 0 sits in the rightmost nibble.
  localparam logic [15:0] DEFAULT_TIME_VALUES =
    {ALARM_ON_DEFAULT, PASSENGER_DEFAULT, DRIVER_DEFAULT, ARM_DEFAULT};

endpackage

// File: rtl/time_parameter_bank.sv
// Reprogrammable delay registers with edge-qualified writes, a registered readout
// and a combinational load path for the countdown timer.
module time_parameter_bank
  import time_parameter_pkg::*;
#(
  parameter int NUM_PARAMS = 4,
  parameter int VALUE_WIDTH = 4,
  parameter logic [NUM_PARAMS*VALUE_WIDTH-1:0] DEFAULT_VALUES = DEFAULT_TIME_VALUES,
  localparam int SEL_WIDTH = $clog2(NUM_PARAMS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   reprogram,
  input  logic [SEL_WIDTH-1:0]   sel,
  input  logic [VALUE_WIDTH-1:0] time_value,
  input  logic [SEL_WIDTH-1:0]   interval,
  output logic [VALUE_WIDTH-1:0] value,
  output logic [VALUE_WIDTH-1:0] load_value,
  output logic                   load_valid
);

  logic [VALUE_WIDTH-1:0] params [NUM_PARAMS];
  logic                   reprogram_q;
  logic                   write_en;

  // A zero delay would make the timer expire immediately, so it is never stored.
  assign write_en   = reprogram && !reprogram_q && (time_value != '0) &&
                      (32'(sel) < NUM_PARAMS);
  assign load_valid = 32'(interval) < NUM_PARAMS;
  assign load_value = load_valid ? params[interval] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PARAMS; i++) begin
        params[i] <= DEFAULT_VALUES[i*VALUE_WIDTH +: VALUE_WIDTH];
      end
      reprogram_q <= 1'b0;
      value       <= '0;
    end else begin
      reprogram_q <= reprogram;
      if (write_en) begin
        params[sel] <= time_value;
      end
      value <= load_value;
    end
  end

endmodule

// File: rtl/time_parameter_timer.sv
// Time-parameter store plus 1 Hz countdown timer used by the car security FSM;
// emits a one-cycle expired pulse after the selected number of ticks.
module time_parameter_timer
  import time_parameter_pkg::*;
#(
  parameter int NUM_PARAMS = 4,
  parameter int VALUE_WIDTH = 4,
  parameter logic [NUM_PARAMS*VALUE_WIDTH-1:0] DEFAULT_VALUES = DEFAULT_TIME_VALUES,
  localparam int SEL_WIDTH = $clog2(NUM_PARAMS)
) (
  input  logic                   clock,
  input  logic                   systemReset,
  input  logic                   reprogram,
  input  logic [SEL_WIDTH-1:0]   timeParameterSelector,
  input  logic [VALUE_WIDTH-1:0] timeValue,
  input  logic [SEL_WIDTH-1:0]   interval,
  input  logic                   startTimer,
  input  logic                   oneHzEnable,
  output logic [VALUE_WIDTH-1:0] value,
  output logic [VALUE_WIDTH-1:0] remaining,
  output logic                   timerBusy,
  output logic                   expired
);

  timer_state_t           state, state_next;
  logic [VALUE_WIDTH-1:0] remaining_next;
  logic [VALUE_WIDTH-1:0] load_value;
  logic                   load_valid;
  logic                   start_ok;

  time_parameter_bank #(
    .NUM_PARAMS    (NUM_PARAMS),
    .VALUE_WIDTH   (VALUE_WIDTH),
    .DEFAULT_VALUES(DEFAULT_VALUES)
  ) u_bank (
    .clk       (clock),
    .rst_n     (systemReset),
    .reprogram (reprogram),
    .sel       (timeParameterSelector),
    .time_value(timeValue),
    .interval  (interval),
    .value     (value),
    .load_value(load_value),
    .load_valid(load_valid)
  );

  assign start_ok = startTimer && load_valid;

  // A start always wins over a coincident tick, so a retrigger restarts the full interval.
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    case (state)
      TIMER_IDLE: begin
        if (start_ok) begin
          remaining_next = load_value;
          state_next     = TIMER_COUNT;
        end
      end
      TIMER_COUNT: begin
        if (start_ok) begin
          remaining_next = load_value;
        end else if (oneHzEnable) begin
          if (remaining == VALUE_WIDTH'(1)) begin
            remaining_next = '0;
            state_next     = TIMER_EXPIRE;
          end else begin
            remaining_next = remaining - VALUE_WIDTH'(1);
          end
        end
      end
      TIMER_EXPIRE: begin
        if (start_ok) begin
          remaining_next = load_value;
          state_next     = TIMER_COUNT;
        end else begin
          state_next = TIMER_IDLE;
        end
      end
      default: begin
        state_next     = TIMER_IDLE;
        remaining_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge systemReset) begin
    if (!systemReset) begin
      state     <= TIMER_IDLE;
      remaining <= '0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
    end
  end

  assign timerBusy = (state == TIMER_COUNT);
  assign expired   = (state == TIMER_EXPIRE);

endmodule
